// File: rtl/program_counter_stack.sv
// Program counter with an integrated return-address stack.
// One operation per cycle by fixed priority: load > branch > call > ret > inc > hold.
module program_counter_stack #(
  parameter int DATA_SIZE   = 16,
  parameter int STACK_DEPTH = 8,
  parameter int INC_STEP    = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [DATA_SIZE-1:0]             in,
  input  logic [DATA_SIZE-1:0]             offset,
  input  logic                             load,
  input  logic                             branch,
  input  logic                             call,
  input  logic                             ret,
  input  logic                             inc,
  input  logic                             clear_err,
  output logic [DATA_SIZE-1:0]             out,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             stack_empty,
  output logic                             stack_full,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int AW = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD, OP_LOAD, OP_BRANCH, OP_CALL, OP_RET, OP_INC
  } op_e;

  logic [DATA_SIZE-1:0] r_pc;
  logic [DW-1:0]        r_depth;
  logic                 r_overflow;
  logic                 r_underflow;
  logic [DATA_SIZE-1:0] r_stack [0:(1<<AW)-1];

  op_e                  w_op;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_ovf_evt;
  logic                 w_unf_evt;
  logic [DATA_SIZE-1:0] w_ret_addr;
  logic [DW-1:0]        w_depth_m1;
  logic [AW-1:0]        w_push_idx;
  logic [AW-1:0]        w_pop_idx;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_op = OP_HOLD;
    if      (load)   w_op = OP_LOAD;
    else if (branch) w_op = OP_BRANCH;
    else if (call)   w_op = OP_CALL;
    else if (ret)    w_op = OP_RET;
    else if (inc)    w_op = OP_INC;
  end

  assign w_full     = (r_depth == DW'(STACK_DEPTH));
  assign w_empty    = (r_depth == '0);
  assign w_push     = (w_op == OP_CALL) && !w_full;
  assign w_pop      = (w_op == OP_RET)  && !w_empty;
  assign w_ovf_evt  = (w_op == OP_CALL) &&  w_full;
  assign w_unf_evt  = (w_op == OP_RET)  &&  w_empty;
  assign w_ret_addr = r_pc + DATA_SIZE'(INC_STEP);
  assign w_depth_m1 = r_depth - DW'(1);
  // Index slices are only used when depth is in range, so the truncation is safe.
  assign w_push_idx = r_depth[AW-1:0];
  assign w_pop_idx  = w_depth_m1[AW-1:0];

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc        <= '0;
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      unique case (w_op)
        OP_LOAD:   r_pc <= in;
        OP_BRANCH: r_pc <= r_pc + offset;
        OP_CALL:   r_pc <= in;
        OP_RET:    if (w_pop) r_pc <= r_stack[w_pop_idx];
        OP_INC:    r_pc <= w_ret_addr;
        default:   r_pc <= r_pc;
      endcase
      if (w_push)     r_depth <= r_depth + DW'(1);
      else if (w_pop) r_depth <= w_depth_m1;
      // A same-cycle error event beats clear_err.
      r_overflow  <= (r_overflow  & ~clear_err) | w_ovf_evt;
      r_underflow <= (r_underflow & ~clear_err) | w_unf_evt;
    end
  end

  // NOTE: stack storage has no reset; entries above depth are never read, and this lets it map to RAM.
  always_ff @(posedge clock) begin
    if (!reset && w_push) r_stack[w_push_idx] <= w_ret_addr;
  end

  assign out         = r_pc;
  assign depth       = r_depth;
  assign stack_empty = w_empty;
  assign stack_full  = w_full;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_program_counter_stack.sv
// Self-checking bench for program_counter_stack: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences (full stack, reset during use).
module tb_program_counter_stack;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] in, offset;
  logic        load, branch, call, ret, inc, clear_err;
  logic [15:0] out;
  logic [3:0]  depth;
  logic        stack_empty, stack_full, overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  program_counter_stack #(.DATA_SIZE(16), .STACK_DEPTH(8), .INC_STEP(1)) dut (
    .clock(clock), .reset(reset), .in(in), .offset(offset),
    .load(load), .branch(branch), .call(call), .ret(ret), .inc(inc),
    .clear_err(clear_err), .out(out), .depth(depth),
    .stack_empty(stack_empty), .stack_full(stack_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        rst, ld, br, cl, rt, ic, ce;
    logic [15:0] din, doff;
    logic [15:0] eout;
    logic [3:0]  edep;
    logic        eovf, eunf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic rst, logic ld, logic br, logic cl,
                              logic rt, logic ic, logic ce, logic [15:0] din,
                              logic [15:0] doff, logic [15:0] eout, logic [3:0] edep,
                              logic eovf, logic eunf);
    vec_t v;
    v.name = name; v.rst = rst; v.ld = ld; v.br = br; v.cl = cl; v.rt = rt;
    v.ic = ic; v.ce = ce; v.din = din; v.doff = doff; v.eout = eout;
    v.edep = edep; v.eovf = eovf; v.eunf = eunf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic ld, input logic br, input logic cl,
                     input logic rt, input logic ic, input logic ce,
                     input logic [15:0] din, input logic [15:0] doff);
    @(negedge clock);
    reset = rst; load = ld; branch = br; call = cl; ret = rt; inc = ic;
    clear_err = ce; in = din; offset = doff;
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string name, input logic [15:0] eout, input logic [3:0] edep,
                             input logic eovf, input logic eunf);
    check({name, ".out"},       out,         eout);
    check({name, ".depth"},     depth,       edep);
    check({name, ".empty"},     stack_empty, edep == 4'd0);
    check({name, ".full"},      stack_full,  edep == 4'd8);
    check({name, ".overflow"},  overflow,    eovf);
    check({name, ".underflow"}, underflow,   eunf);
  endtask

  initial begin
    reset = 1'b1; load = 0; branch = 0; call = 0; ret = 0; inc = 0; clear_err = 0;
    in = '0; offset = '0;

    //                 name          rst ld br cl rt ic ce  in       offset   out      dep ovf unf
    vecs.push_back(mk("reset",        1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("inc1",         0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0001, 0, 0, 0));
    vecs.push_back(mk("inc2",         0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0002, 0, 0, 0));
    vecs.push_back(mk("inc3",         0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0003, 0, 0, 0));
    vecs.push_back(mk("load_inc",     0, 1, 0, 0, 0, 1, 0, 16'h1234, 16'h0000, 16'h1234, 0, 0, 0));
    vecs.push_back(mk("load_0100",    0, 1, 0, 0, 0, 0, 0, 16'h0100, 16'h0000, 16'h0100, 0, 0, 0));
    vecs.push_back(mk("branch_neg",   0, 0, 1, 0, 0, 0, 0, 16'h0000, 16'hFFF0, 16'h00F0, 0, 0, 0));
    vecs.push_back(mk("branch_call",  0, 0, 1, 1, 0, 1, 0, 16'h0777, 16'h0005, 16'h00F5, 0, 0, 0));
    vecs.push_back(mk("load_ffff",    0, 1, 0, 0, 0, 0, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 0, 0));
    vecs.push_back(mk("inc_wrap",     0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("hold",         0, 0, 0, 0, 0, 0, 0, 16'h5555, 16'h1111, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("load_0010",    0, 1, 0, 0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0010, 0, 0, 0));
    vecs.push_back(mk("call_0200",    0, 0, 0, 1, 0, 0, 0, 16'h0200, 16'h0000, 16'h0200, 1, 0, 0));
    vecs.push_back(mk("ret_0011",     0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0011, 0, 0, 0));
    vecs.push_back(mk("ret_empty",    0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0011, 0, 0, 1));
    vecs.push_back(mk("sticky_unf",   0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0011, 0, 0, 1));
    vecs.push_back(mk("clear_err",    0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0011, 0, 0, 0));
    vecs.push_back(mk("clr_and_unf",  0, 0, 0, 0, 1, 0, 1, 16'h0000, 16'h0000, 16'h0011, 0, 0, 1));
    vecs.push_back(mk("clear_err2",   0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0011, 0, 0, 0));
    vecs.push_back(mk("call_over_ret",0, 0, 0, 1, 1, 1, 0, 16'h0300, 16'h0000, 16'h0300, 1, 0, 0));
    vecs.push_back(mk("ret_over_inc", 0, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 16'h0012, 0, 0, 0));

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].ld, vecs[i].br, vecs[i].cl, vecs[i].rt, vecs[i].ic,
          vecs[i].ce, vecs[i].din, vecs[i].doff);
      check_state(vecs[i].name, vecs[i].eout, vecs[i].edep, vecs[i].eovf, vecs[i].eunf);
    end

    // Fill the stack: first call pushes 0x1001, call k pushes 0x2000+k.
    cyc(0, 1, 0, 0, 0, 0, 0, 16'h1000, 16'h0000);
    check_state("fill_load", 16'h1000, 4'd0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 1, 0, 0, 0, 16'h2000 + 16'(k), 16'h0000);
      check_state($sformatf("fill_call%0d", k), 16'h2000 + 16'(k), 4'(k + 1), 0, 0);
    end
    cyc(0, 0, 0, 1, 0, 0, 0, 16'h2008, 16'h0000);
    check_state("call_full", 16'h2008, 4'd8, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, 16'h2009, 16'h0000);
    check_state("call_full_clr", 16'h2009, 4'd8, 1, 0);
    for (int k = 7; k >= 1; k--) begin
      cyc(0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000);
      check_state($sformatf("drain%0d", k), 16'h2000 + 16'(k), 4'(k), 1, 0);
    end
    cyc(0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000);
    check_state("drain_last", 16'h1001, 4'd0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000);
    check_state("clear_ovf", 16'h1001, 4'd0, 0, 0);

    // Reset in the middle of stack use overrides a simultaneous call.
    cyc(0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000);
    check_state("pre_unf", 16'h1001, 4'd0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 16'h0A00, 16'h0000);
    cyc(0, 0, 0, 1, 0, 0, 0, 16'h0B00, 16'h0000);
    cyc(0, 0, 0, 1, 0, 0, 0, 16'h0C00, 16'h0000);
    check_state("depth3", 16'h0C00, 4'd3, 0, 1);
    cyc(1, 0, 0, 1, 0, 0, 0, 16'h0D00, 16'h0000);
    check_state("reset_call", 16'h0000, 4'd0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000);
    check_state("post_reset_ret", 16'h0000, 4'd0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_counter_stack.md
PROGRAM_COUNTER_STACK -- requirements
Module: program_counter_stack

Interface
REQ-001 Parameter DATA_SIZE, default 16: width of PC, load target, branch offset and stack entries.
REQ-002 Parameter STACK_DEPTH, default 8: number of return-address entries; legal range 2..64.
REQ-003 Parameter INC_STEP, default 1: amount added by inc and pushed-return computation.
REQ-004 clock  input  1  main clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in  input  DATA_SIZE  absolute target for load and call.
REQ-007 offset  input  DATA_SIZE  two's-complement signed displacement for branch.
REQ-008 load, branch, call, ret, inc  input  1 each  operation requests.
REQ-009 clear_err  input  1  clears sticky error flags.
REQ-010 out  output  DATA_SIZE  current program counter, registered.
REQ-011 depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries, registered.
REQ-012 stack_empty, stack_full  output  1 each  depth==0, depth==STACK_DEPTH; combinational from depth.
REQ-013 overflow, underflow  output  1 each  sticky error flags, registered.

Function
REQ-014 Exactly one operation SHALL take effect per cycle, by fixed priority load > branch > call > ret > inc > hold.
REQ-015 load: out <= in next cycle; stack untouched.
REQ-016 branch: out <= out + offset (sign-extended, modulo 2^DATA_SIZE); stack untouched.
REQ-017 inc: out <= out + INC_STEP modulo 2^DATA_SIZE; 0xFFFF+1 wraps to 0x0000 at default width.
REQ-018 hold (no request): out, stack, depth unchanged.
REQ-019 call, not full: stack[depth] <= out + INC_STEP (wrapped), depth <= depth+1, out <= in, all in one cycle.
REQ-020 call, full: out <= in, push discarded, depth and entries unchanged, overflow <= 1.
REQ-021 ret, not empty: out <= stack[depth-1], depth <= depth-1.
REQ-022 ret, empty: out and depth unchanged, underflow <= 1.
REQ-023 Stack is LIFO; entries at index >= depth are don't-care and never observable on out.
REQ-024 Lower-priority requests asserted alongside a higher one SHALL be ignored with no side effect (no push, pop, or flag).
REQ-025 clear_err: overflow and underflow <= 0 next cycle; if an overflow/underflow event occurs in the same cycle, the set wins.
REQ-026 All operations SHALL have single-cycle latency: effect visible on out/depth/flags the cycle after the request edge.
REQ-027 Stack storage SHALL be flip-flops or inferred RAM with synchronous write; pop data path SHALL not add latency.

Reset
REQ-028 reset asserted at a rising edge: out <= 0, depth <= 0, overflow <= 0, underflow <= 0.
REQ-029 reset SHALL override every operation request in the same cycle, including mid call/ret sequences.
REQ-030 Stack entry contents need not be cleared by reset.
REQ-031 After reset deassertion, the first edge with a request SHALL execute it normally.

Verification
REQ-032 Reset, then inc x3 -> out 0,1,2,3; load in=0x1234 with inc -> out 0x1234.
REQ-033 out=0x0100, branch offset=0xFFF0 -> out 0x00F0; out=0xFFFF, inc -> out 0x0000.
REQ-034 out=0x0010, call in=0x0200 -> out 0x0200, depth 1; ret -> out 0x0011, depth 0, stack_empty 1.
REQ-035 STACK_DEPTH=8: nine calls -> depth 8, stack_full 1, overflow 1, ninth target on out; eight rets return addresses in reverse order.
REQ-036 ret on empty -> out unchanged, underflow 1; clear_err -> underflow 0; clear_err with ret on empty -> underflow stays 1.
REQ-037 depth 3, reset asserted together with call -> out 0, depth 0, flags 0; subsequent ret -> underflow 1.
